// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider controller:
//   - state_e      : controller state encoding (IDLE, RUN, SWITCH_PEND, DRAIN)
//   - DIV_MIN      : smallest legal divide ratio
//   - high_thresh  : number of reference cycles o_div_clk is high per period
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      RUN         = 2'd1,
      SWITCH_PEND = 2'd2,
      DRAIN       = 2'd3
   } state_e;

   localparam int unsigned DIV_MIN = 32'd2;

   // High phase covers counts 0 .. (N>>1)-1, so odd N is high floor(N/2).
   function automatic logic [31:0] high_thresh(input logic [31:0] n);
      return n >> 32'd1;
   endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Ratio configuration handshake between register logic and the divider.
//   i_cfg_valid : new ratio offered            (master -> slave)
//   i_cfg_div   : requested ratio N, WIDTH bits (master -> slave)
//   o_cfg_ready : controller can take a ratio   (slave -> master)
//   o_cfg_err   : 1-cycle pulse, ratio rejected (slave -> master)
// A transfer happens in any cycle with i_cfg_valid & o_cfg_ready.
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             i_cfg_valid;
   logic [WIDTH-1:0] i_cfg_div;
   logic             o_cfg_ready;
   logic             o_cfg_err;

   modport master (
      output i_cfg_valid,
      output i_cfg_div,
      input  o_cfg_ready,
      input  o_cfg_err
   );

   modport slave (
      input  i_cfg_valid,
      input  i_cfg_div,
      output o_cfg_ready,
      output o_cfg_err
   );
endinterface

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Phase counter, period-end detection and divided-clock waveform.
// Optional macro CLK_DIV_DUTY50_EN adds a negedge flop giving 50% duty for odd
// ratios; without it odd N is high floor(N/2) cycles and low ceil(N/2).
// Ports:
//   clk, resetn     : reference clock, async active-low reset
//   cur_div_i       : ratio in effect this cycle (sets the wrap point)
//   nxt_div_i       : ratio in effect next cycle (shapes registered outputs)
//   run_i           : controller is running this cycle, counter advances
//   clear_i         : controller is idle next cycle, counter forced to 0
//   wrap_o          : this cycle is the last of the period (combinational)
//   count_o         : registered phase counter
//   div_clk_o       : divided clock
//   period_end_o    : registered last-cycle-of-period flag
// -----------------------------------------------------------------------------
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] cur_div_i,
   input  logic [WIDTH-1:0] nxt_div_i,
   input  logic             run_i,
   input  logic             clear_i,
   output logic             wrap_o,
   output logic [WIDTH-1:0] count_o,
   output logic             div_clk_o,
   output logic             period_end_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             pos_q, pos_d;
   logic             pe_q, pe_d;
   logic [WIDTH-1:0] last_s;
   logic [WIDTH-1:0] nxt_last_s;

   // Only compare against N-1, so the counter never overflows for legal N.
   assign last_s     = cur_div_i - WIDTH'(1);
   assign nxt_last_s = nxt_div_i - WIDTH'(1);
   assign wrap_o     = run_i & (count_q == last_s);

   // Next count and the waveform/period-end values it implies; outputs are
   // computed from next-state values so they can be registered.
   always_comb begin
      count_d = '0;
      pos_d   = 1'b0;
      pe_d    = 1'b0;
      if (clear_i) begin
         count_d = '0;
         pos_d   = 1'b0;
         pe_d    = 1'b0;
      end else begin
         // The first running cycle after IDLE shows count 0, hence !run_i -> 0.
         if (run_i && !wrap_o) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = '0;
         end
         pos_d = (32'(count_d) < high_thresh(32'(nxt_div_i)));
         pe_d  = (count_d == nxt_last_s);
      end
   end

   // Counter and posedge waveform registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         pos_q   <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         pos_q   <= pos_d;
         pe_q    <= pe_d;
      end
   end

   assign count_o      = count_q;
   assign period_end_o = pe_q;

`ifdef CLK_DIV_DUTY50_EN
   logic neg_q;

   // Half-cycle delayed copy of the posedge waveform for odd-ratio stretch.
   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= pos_q;
      end
   end

   // OR-ing the delayed copy extends the high phase by half a reference cycle.
   assign div_clk_o = cur_div_i[0] ? (pos_q | neg_q) : pos_q;
`else
   assign div_clk_o = pos_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time programmable integer clock divider controller. Starts/stops the
// divided clock and takes ratio changes over a valid/ready handshake; stops
// and ratio changes only land on a period boundary so o_div_clk never glitches.
// Optional macro CLK_DIV_DUTY50_EN: 50% duty for odd ratios (see clk_div_core).
// Ports:
//   clk, resetn   : reference clock, async active-low reset
//   i_start       : begin generating the divided clock (ignored unless IDLE)
//   i_stop        : stop at the end of the current period (wins over i_start)
//   cfg_if        : ratio handshake (i_cfg_valid/i_cfg_div/o_cfg_ready/o_cfg_err)
//   o_busy        : controller not IDLE
//   o_div_clk     : divided clock
//   o_period_end  : pulse on the last cycle of each period
//   o_cur_div     : ratio currently in effect
//   o_count       : phase counter 0..o_cur_div-1
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_DIV = 7
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_start,
   input  logic               i_stop,
   clk_div_ctrl_if.slave      cfg_if,
   output logic               o_busy,
   output logic               o_div_clk,
   output logic               o_period_end,
   output logic [WIDTH-1:0]   o_cur_div,
   output logic [WIDTH-1:0]   o_count
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cur_div_q, cur_div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             stop_q, stop_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cfg_ready_s;
   logic             cfg_fire_s;
   logic             cfg_bad_s;
   logic             cfg_ok_s;
   logic             running_s;
   logic             wrap_s;

   assign running_s   = (state_q != IDLE);
   assign cfg_ready_s = (state_q == IDLE) || (state_q == RUN);
   assign cfg_fire_s  = cfg_if.i_cfg_valid & cfg_ready_s;
   // Ratios 0 and 1 cannot form a period with a high and a low phase.
   assign cfg_bad_s   = cfg_fire_s & (32'(cfg_if.i_cfg_div) < DIV_MIN);
   assign cfg_ok_s    = cfg_fire_s & ~cfg_bad_s;

   // Controller next-state, ratio, pending and stop-flag decisions.
   always_comb begin
      state_d   = state_q;
      cur_div_d = cur_div_q;
      pend_d    = pend_q;
      stop_d    = stop_q;
      cfg_err_d = cfg_bad_s;
      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (cfg_ok_s) begin
               cur_div_d = cfg_if.i_cfg_div;
            end else begin
               cur_div_d = cur_div_q;
            end
            if (i_start && !i_stop) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // A stop arriving with an accepted ratio is remembered so the new
            // ratio still lands before the controller goes idle.
            if (cfg_ok_s) begin
               pend_d  = cfg_if.i_cfg_div;
               stop_d  = i_stop;
               state_d = SWITCH_PEND;
            end else if (i_stop) begin
               state_d = DRAIN;
            end else begin
               state_d = RUN;
            end
         end
         SWITCH_PEND: begin
            if (wrap_s) begin
               cur_div_d = pend_q;
               stop_d    = 1'b0;
               if (stop_q || i_stop) begin
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               // Latch a stop pulse seen mid-period so it is not lost.
               stop_d  = stop_q | i_stop;
               state_d = SWITCH_PEND;
            end
         end
         DRAIN: begin
            if (wrap_s) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            stop_d  = 1'b0;
         end
      endcase
   end

   // Controller state and registered handshake outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cur_div_q <= WIDTH'(DEFAULT_DIV);
         pend_q    <= '0;
         stop_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_div_q <= cur_div_d;
         pend_q    <= pend_d;
         stop_q    <= stop_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   clk_div_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk          (clk),
      .resetn       (resetn),
      .cur_div_i    (cur_div_q),
      .nxt_div_i    (cur_div_d),
      .run_i        (running_s),
      .clear_i      (state_d == IDLE),
      .wrap_o       (wrap_s),
      .count_o      (o_count),
      .div_clk_o    (o_div_clk),
      .period_end_o (o_period_end)
   );

   assign o_busy             = running_s;
   assign o_cur_div          = cur_div_q;
   assign cfg_if.o_cfg_ready = cfg_ready_s;
   assign cfg_if.o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed stimulus with hand-derived per-cycle expectations pushed into a
// queue; a monitor pops one entry per clock and compares all outputs.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int W = 4;

   logic         clk;
   logic         resetn;
   logic         i_start;
   logic         i_stop;
   logic         o_busy;
   logic         o_div_clk;
   logic         o_period_end;
   logic [W-1:0] o_cur_div;
   logic [W-1:0] o_count;

   clk_div_ctrl_if #(.WIDTH(W)) cfg_if ();

   clk_div_ctrl #(
      .WIDTH      (W),
      .DEFAULT_DIV(7)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .cfg_if       (cfg_if.slave),
      .o_busy       (o_busy),
      .o_div_clk    (o_div_clk),
      .o_period_end (o_period_end),
      .o_cur_div    (o_cur_div),
      .o_count      (o_count)
   );

   typedef struct {
      int    cnt;
      int    dclk;
      int    pe;
      int    div;
      int    busy;
      int    rdy;
      int    err;
      string tag;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Expected o_div_clk for a sample taken just after the edge showing count k.
   function automatic int exp_clk(input int k, input int n);
      int v;
      v = (k < (n / 2)) ? 1 : 0;
`ifdef CLK_DIV_DUTY50_EN
      if ((n % 2) == 1 && k == (n / 2)) v = 1;
`endif
      return v;
   endfunction

   function automatic exp_t er(input int k, input int n, input int rdy, input int err, input string tag);
      exp_t e;
      e.cnt = k; e.dclk = exp_clk(k, n); e.pe = (k == n - 1) ? 1 : 0;
      e.div = n; e.busy = 1; e.rdy = rdy; e.err = err; e.tag = tag;
      return e;
   endfunction

   function automatic exp_t ei(input int n, input int err, input string tag);
      exp_t e;
      e.cnt = 0; e.dclk = 0; e.pe = 0; e.div = n; e.busy = 0; e.rdy = 1; e.err = err; e.tag = tag;
      return e;
   endfunction

   task automatic cmp_all(input exp_t e);
      chk({e.tag, "_count"},   int'(o_count),            e.cnt);
      chk({e.tag, "_divclk"},  int'(o_div_clk),          e.dclk);
      chk({e.tag, "_pend"},    int'(o_period_end),       e.pe);
      chk({e.tag, "_curdiv"},  int'(o_cur_div),          e.div);
      chk({e.tag, "_busy"},    int'(o_busy),             e.busy);
      chk({e.tag, "_ready"},   int'(cfg_if.o_cfg_ready), e.rdy);
      chk({e.tag, "_err"},     int'(cfg_if.o_cfg_err),   e.err);
   endtask

   // Monitor: one expectation per clock edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp_all(e);
         end
      end
   end

   task automatic drv(input bit st, input bit sp, input bit cv, input logic [W-1:0] cd, input exp_t e);
      i_start            = st;
      i_stop             = sp;
      cfg_if.i_cfg_valid = cv;
      cfg_if.i_cfg_div   = cd;
      q.push_back(e);
      @(posedge clk);
      #2;
      i_start            = 1'b0;
      i_stop             = 1'b0;
      cfg_if.i_cfg_valid = 1'b0;
      cfg_if.i_cfg_div   = '0;
   endtask

   task automatic run_span(input int n, input int k0, input int k1, input string tag);
      for (int k = k0; k <= k1; k++) drv(1'b0, 1'b0, 1'b0, '0, er(k, n, 1, 0, tag));
   endtask

   initial begin
      real t0, t1;
      exp_t r;
      i_start = 1'b0; i_stop = 1'b0;
      cfg_if.i_cfg_valid = 1'b0; cfg_if.i_cfg_div = '0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp_all(ei(7, 0, "reset"));
      #1;
      resetn = 1'b1;

      // IDLE configuration then start at N=7: 1110000, period end at count 6.
      drv(1'b0, 1'b0, 1'b1, 4'd9, ei(9, 0, "cfg9_idle"));
      drv(1'b0, 1'b0, 1'b1, 4'd7, ei(7, 0, "cfg7_idle"));
      drv(1'b1, 1'b0, 1'b0, '0, er(0, 7, 1, 0, "start7"));
      run_span(7, 1, 6, "run7a");
      run_span(7, 0, 6, "run7b");
      run_span(7, 0, 2, "run7c");

      // N=4 accepted at count 2; ready low until the count 6 period end.
      drv(1'b0, 1'b0, 1'b1, 4'd4, er(3, 7, 0, 0, "pend4"));
      for (int k = 4; k <= 6; k++) drv(1'b0, 1'b0, 1'b0, '0, er(k, 7, 0, 0, "pend4"));
      run_span(4, 0, 3, "run4a");
      run_span(4, 0, 3, "run4b");

      // Illegal ratios while running.
      drv(1'b0, 1'b0, 1'b1, 4'd1, er(0, 4, 1, 1, "err1"));
      drv(1'b0, 1'b0, 1'b0, '0,   er(1, 4, 1, 0, "err1_clr"));
      drv(1'b0, 1'b0, 1'b1, 4'd0, er(2, 4, 1, 1, "err0"));
      drv(1'b0, 1'b0, 1'b0, '0,   er(3, 4, 1, 0, "err0_clr"));

      // N=5 accepted on the wrap cycle waits a whole period.
      drv(1'b0, 1'b0, 1'b1, 4'd5, er(0, 4, 0, 0, "pend5_wrap"));
      for (int k = 1; k <= 3; k++) drv(1'b0, 1'b0, 1'b0, '0, er(k, 4, 0, 0, "pend5_wrap"));
      drv(1'b0, 1'b0, 1'b0, '0, er(0, 5, 1, 0, "run5"));
      drv(1'b1, 1'b0, 1'b0, '0, er(1, 5, 1, 0, "start_ignored"));

      // Stop at count 1 drains to the end of the period.
      drv(1'b0, 1'b1, 1'b0, '0, er(2, 5, 0, 0, "drain"));
      drv(1'b0, 1'b0, 1'b0, '0, er(3, 5, 0, 0, "drain"));
      drv(1'b0, 1'b0, 1'b0, '0, er(4, 5, 0, 0, "drain"));
      drv(1'b0, 1'b0, 1'b0, '0, ei(5, 0, "drain_idle"));
      drv(1'b0, 1'b0, 1'b0, '0, ei(5, 0, "idle_hold"));
      drv(1'b1, 1'b0, 1'b0, '0, er(0, 5, 1, 0, "restart"));
      drv(1'b0, 1'b0, 1'b0, '0, er(1, 5, 1, 0, "restart"));

      // Simultaneous ratio 3 and stop: ratio lands, then IDLE.
      drv(1'b0, 1'b1, 1'b1, 4'd3, er(2, 5, 0, 0, "cfg3_stop"));
      drv(1'b0, 1'b0, 1'b0, '0, er(3, 5, 0, 0, "cfg3_stop"));
      drv(1'b0, 1'b0, 1'b0, '0, er(4, 5, 0, 0, "cfg3_stop"));
      drv(1'b0, 1'b0, 1'b0, '0, ei(3, 0, "cfg3_stop_idle"));
      drv(1'b1, 1'b1, 1'b0, '0, ei(3, 0, "start_stop_idle"));
      drv(1'b0, 1'b0, 1'b1, 4'd1, ei(3, 1, "idle_err"));
      drv(1'b0, 1'b0, 1'b0, '0,   ei(3, 0, "idle_err_clr"));

      // N=3 waveform 100, then move to N=9.
      drv(1'b1, 1'b0, 1'b0, '0, er(0, 3, 1, 0, "start3"));
      run_span(3, 1, 2, "run3");
      run_span(3, 0, 0, "run3");
      drv(1'b0, 1'b0, 1'b1, 4'd9, er(1, 3, 0, 0, "pend9"));
      drv(1'b0, 1'b0, 1'b0, '0,   er(2, 3, 0, 0, "pend9"));
      drv(1'b0, 1'b0, 1'b0, '0,   er(0, 9, 1, 0, "run9"));
      run_span(9, 1, 3, "run9");

      // Asynchronous reset mid-period while o_div_clk is high.
      chk("queue_drained", q.size(), 0);
      #2;
      resetn = 1'b0;
      #1;
      cmp_all(ei(7, 0, "async_reset"));
      @(posedge clk);
      #2;
      resetn = 1'b1;
      drv(1'b0, 1'b0, 1'b0, '0, ei(7, 0, "post_reset"));

      // High-time measurement at N=7.
      drv(1'b1, 1'b0, 1'b0, '0, er(0, 7, 1, 0, "start7_meas"));
      run_span(7, 1, 6, "run7_meas");
      chk("queue_drained2", q.size(), 0);
      t0 = 0.0; t1 = 0.0;
      fork
         begin
            @(posedge o_div_clk);
            t0 = $realtime;
            @(negedge o_div_clk);
            t1 = $realtime;
         end
         begin
            #500;
         end
      join_any
      disable fork;
`ifdef CLK_DIV_DUTY50_EN
      chk("high_time_x10", int'(t1 - t0), 35);
`else
      chk("high_time_x10", int'(t1 - t0), 30);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
